// File: rtl/seg7_capture.sv
// Recovers hex digits from a multiplexed seven-segment bus. Each digit is captured once its
// pattern has been stable long enough, and a full frame is then offered over valid/ready.
module seg7_capture #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] out_digits,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
);

  localparam logic [7:0] StableMax = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {StIdle, StTrack, StHold} state_e;

  state_e                  state_q, state_d;
  logic [6:0]              samp_seg_q, prev_seg_q;
  logic [NUM_DIGITS-1:0]   samp_an_q, prev_an_q;
  logic [7:0]              cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] slot_digits_q, slot_digits_d;
  logic [NUM_DIGITS-1:0]   slot_err_q, slot_err_d;
  logic [4*NUM_DIGITS-1:0] out_digits_q, out_digits_d;
  logic [NUM_DIGITS-1:0]   out_err_q, out_err_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overrun_q, overrun_d;

  logic       an_onehot;
  logic       change;
  logic       capture;
  logic       complete;
  logic [4:0] dec;

  // Returns {illegal, value}; illegal patterns decode to value 0.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h3F:   r = 5'h00;
      7'h06:   r = 5'h01;
      7'h5B:   r = 5'h02;
      7'h4F:   r = 5'h03;
      7'h66:   r = 5'h04;
      7'h6D:   r = 5'h05;
      7'h7D:   r = 5'h06;
      7'h07:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h6F:   r = 5'h09;
      7'h77:   r = 5'h0A;
      7'h7C:   r = 5'h0B;
      7'h39:   r = 5'h0C;
      7'h5E:   r = 5'h0D;
      7'h79:   r = 5'h0E;
      7'h71:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  assign an_onehot = $onehot(samp_an_q);
  assign change    = {samp_an_q, samp_seg_q} != {prev_an_q, prev_seg_q};
  assign complete  = &mask_q;
  assign dec       = decode(samp_seg_q);

  // Capture fires on the edge where the count reaches StableMax, so a digit held from edge e
  // lands in its slot at edge e+STABLE_CYCLES.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = 8'd0;
        if (an_onehot) begin
          state_d = StTrack;
          cnt_d   = 8'd1;
        end
      end
      StTrack: begin
        if (!an_onehot) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else if (change) begin
          cnt_d = 8'd1;
        end else begin
          cnt_d = (cnt_q < StableMax) ? cnt_q + 8'd1 : cnt_q;
          if (cnt_d == StableMax) begin
            capture = 1'b1;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (!an_onehot) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else if (change) begin
          state_d = StTrack;
          cnt_d   = 8'd1;
        end else begin
          cnt_d = (cnt_q < StableMax) ? cnt_q + 8'd1 : cnt_q;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_comb begin
    mask_d        = mask_q;
    slot_digits_d = slot_digits_q;
    slot_err_d    = slot_err_q;
    out_digits_d  = out_digits_q;
    out_err_d     = out_err_q;
    out_valid_d   = out_valid_q;
    overrun_d     = overrun_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (complete) begin
      mask_d = '0;
      if (!out_valid_q || out_ready) begin
        out_digits_d = slot_digits_q;
        out_err_d    = slot_err_q;
        out_valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (capture && samp_an_q[i]) begin
        slot_digits_d[4*i +: 4] = dec[3:0];
        slot_err_d[i]           = dec[4];
        mask_d[i]               = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      samp_seg_q    <= '0;
      samp_an_q     <= '0;
      prev_seg_q    <= '0;
      prev_an_q     <= '0;
      cnt_q         <= '0;
      mask_q        <= '0;
      slot_digits_q <= '0;
      slot_err_q    <= '0;
      out_digits_q  <= '0;
      out_err_q     <= '0;
      out_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      samp_seg_q    <= seg;
      samp_an_q     <= an;
      prev_seg_q    <= samp_seg_q;
      prev_an_q     <= samp_an_q;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      slot_digits_q <= slot_digits_d;
      slot_err_q    <= slot_err_d;
      out_digits_q  <= out_digits_d;
      out_err_q     <= out_err_d;
      out_valid_q   <= out_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign out_digits = out_digits_q;
  assign out_err    = out_err_q;
  assign out_valid  = out_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: a table of full-frame scans plus hand-written sequences
// for glitches, enable collisions, minimum dwell, backpressure, reset and overwrite.
module tb_seg7_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] out_digits;
  logic [3:0]  out_err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  always #5 clk = ~clk;

  seg7_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .seg        (seg),
    .an         (an),
    .out_digits (out_digits),
    .out_err    (out_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int rises = 0;
  int vcycles = 0;
  int rise_cyc = 0;
  logic valid_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame monitor: counts out_valid cycles and rising edges, noting the edge of each rise.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      vcycles <= vcycles + 1;
      if (valid_prev !== 1'b1) begin
        rises    <= rises + 1;
        rise_cyc <= cyc;
      end
    end
    valid_prev <= out_valid;
  end

  typedef struct {
    logic [27:0] segs;    // {d3, d2, d1, d0}
    logic [15:0] digits;
    logic [3:0]  err;
  } vec_t;

  vec_t vecs[5];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    step(n);
  endtask

  // e3 is the edge that first samples digit 3.
  task automatic scan(input logic [27:0] segs, input int n, output int e3);
    logic [27:0] sv;
    sv = segs;
    e3 = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) e3 = cyc + 1;
      dwell(4'(1 << i), sv[7*i +: 7], n);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  int e3;
  int r0;
  int c0;

  initial begin
    vecs[0] = '{segs: {7'h4F, 7'h5B, 7'h06, 7'h3F}, digits: 16'h3210, err: 4'b0000};
    vecs[1] = '{segs: {7'h7C, 7'h77, 7'h6F, 7'h7F}, digits: 16'hBA98, err: 4'b0000};
    vecs[2] = '{segs: {7'h71, 7'h79, 7'h5E, 7'h39}, digits: 16'hFEDC, err: 4'b0000};
    vecs[3] = '{segs: {7'h07, 7'h7D, 7'h6D, 7'h66}, digits: 16'h7654, err: 4'b0000};
    vecs[4] = '{segs: {7'h3F, 7'h08, 7'h7C, 7'h00}, digits: 16'h00B0, err: 4'b0101};

    reset     = 1'b1;
    seg       = 7'h00;
    an        = 4'b0000;
    out_ready = 1'b0;
    step(3);
    reset = 1'b0;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_digits", 32'(out_digits), 32'd0);
    check("reset out_err", 32'(out_err), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);

    // Table of full frames, consumer always ready.
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      r0 = rises;
      c0 = vcycles;
      scan(vecs[v].segs, 8, e3);
      dwell(4'b0000, 7'h00, 3);
      check($sformatf("vec%0d digits", v), 32'(out_digits), 32'(vecs[v].digits));
      check($sformatf("vec%0d err", v), 32'(out_err), 32'(vecs[v].err));
      check($sformatf("vec%0d valid rises", v), 32'(rises - r0), 32'd1);
      check($sformatf("vec%0d valid width", v), 32'(vcycles - c0), 32'd1);
      check($sformatf("vec%0d frame latency", v), 32'(rise_cyc), 32'(e3 + 5));
    end

    // Short glitch on digit 1 is ignored; blank on digit 2 is flagged.
    r0 = rises;
    dwell(4'b0001, 7'h3F, 8);
    dwell(4'b0010, 7'h7F, 2);
    dwell(4'b0010, 7'h7C, 8);
    dwell(4'b0100, 7'h00, 8);
    dwell(4'b1000, 7'h3F, 8);
    dwell(4'b0000, 7'h00, 3);
    check("glitch digits", 32'(out_digits), 32'h00B0);
    check("glitch err", 32'(out_err), 32'b0100);
    check("glitch rises", 32'(rises - r0), 32'd1);

    // Two enables at once must not disturb the partial frame.
    r0 = rises;
    dwell(4'b0001, 7'h06, 8);
    dwell(4'b0010, 7'h5B, 8);
    dwell(4'b0100, 7'h4F, 8);
    dwell(4'b0011, 7'h7F, 20);
    check("multi-an no frame", 32'(rises - r0), 32'd0);
    dwell(4'b1000, 7'h66, 8);
    dwell(4'b0000, 7'h00, 3);
    check("multi-an digits", 32'(out_digits), 32'h4321);
    check("multi-an err", 32'(out_err), 32'd0);
    check("multi-an rises", 32'(rises - r0), 32'd1);

    // Minimum dwell: STABLE_CYCLES captures, one fewer does not.
    r0 = rises;
    dwell(4'b0001, 7'h7D, 4);
    dwell(4'b0010, 7'h07, 4);
    dwell(4'b0100, 7'h7F, 4);
    dwell(4'b1000, 7'h6F, 3);
    dwell(4'b0000, 7'h00, 10);
    check("short dwell no frame", 32'(rises - r0), 32'd0);
    dwell(4'b1000, 7'h4F, 4);
    dwell(4'b0000, 7'h00, 4);
    check("min dwell rises", 32'(rises - r0), 32'd1);
    check("min dwell digits", 32'(out_digits), 32'h3876);

    // Backpressure: first frame held, second dropped.
    out_ready = 1'b0;
    r0 = rises;
    scan(vecs[0].segs, 8, e3);
    dwell(4'b0000, 7'h00, 3);
    check("bp first valid", 32'(out_valid), 32'd1);
    check("bp first digits", 32'(out_digits), 32'h3210);
    check("bp no overrun yet", 32'(overrun), 32'd0);
    scan(vecs[1].segs, 8, e3);
    dwell(4'b0000, 7'h00, 3);
    check("bp held valid", 32'(out_valid), 32'd1);
    check("bp held digits", 32'(out_digits), 32'h3210);
    check("bp held err", 32'(out_err), 32'd0);
    check("bp overrun", 32'(overrun), 32'd1);
    check("bp single rise", 32'(rises - r0), 32'd1);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("bp valid falls", 32'(out_valid), 32'd0);
    check("bp overrun sticky", 32'(overrun), 32'd1);

    // Reset with a pending frame and a partial frame in flight.
    scan(vecs[2].segs, 8, e3);
    dwell(4'b0000, 7'h00, 3);
    check("pending valid", 32'(out_valid), 32'd1);
    dwell(4'b0001, 7'h3F, 8);
    dwell(4'b0010, 7'h06, 8);
    an    = 4'b0100;
    seg   = 7'h5B;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    check("mid reset valid", 32'(out_valid), 32'd0);
    check("mid reset digits", 32'(out_digits), 32'd0);
    check("mid reset err", 32'(out_err), 32'd0);
    check("mid reset overrun", 32'(overrun), 32'd0);
    r0 = rises;
    c0 = vcycles;
    out_ready = 1'b1;
    dwell(4'b0100, 7'h5B, 8);
    dwell(4'b1000, 7'h4F, 8);
    check("post reset no valid", 32'(vcycles - c0), 32'd0);
    check("post reset digits", 32'(out_digits), 32'd0);

    // Overwrite: latest capture of digit 0 wins.
    an    = 4'b0000;
    seg   = 7'h00;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    r0 = rises;
    dwell(4'b0001, 7'h06, 8);
    dwell(4'b0001, 7'h66, 8);
    dwell(4'b0010, 7'h06, 8);
    dwell(4'b0100, 7'h5B, 8);
    dwell(4'b1000, 7'h4F, 8);
    dwell(4'b0000, 7'h00, 3);
    check("overwrite rises", 32'(rises - r0), 32'd1);
    check("overwrite digits", 32'(out_digits), 32'h3214);
    check("overwrite err", 32'(out_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
